// File: rtl/fetch_if.sv
// Fetch unit bus: control-unit handshake (fetch_req/jump/ir/opcode/status)
// and program-memory request/acknowledge channel.
//   master : the fetch unit (drives mem_rd/mem_addr, ir, opcode, status, pc)
//   slave  : the environment (control unit + program memory)
interface fetch_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned WORD_W = 16
);
  logic              fetch_req;
  logic              jump_en;
  logic [ADDR_W-1:0] jump_addr;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [WORD_W-1:0] ir;
  logic [4:0]        opcode;
  logic              ir_valid;
  logic              busy;
  logic              halted;
  logic [ADDR_W-1:0] pc;

  modport master (
    input  fetch_req, jump_en, jump_addr, mem_rdata, mem_ack,
    output mem_rd, mem_addr, ir, opcode, ir_valid, busy, halted, pc
  );

  modport slave (
    output fetch_req, jump_en, jump_addr, mem_rdata, mem_ack,
    input  mem_rd, mem_addr, ir, opcode, ir_valid, busy, halted, pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns PC and IR, fetches one word per request from
// program memory over a req/ack handshake and presents ir/opcode to the
// control unit. Halts permanently (until reset) on opcode HALT_OP.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : fetch_if.master (control handshake, memory channel, status)
module fetch_unit #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned WORD_W  = 16,
  parameter logic [4:0]  HALT_OP = 5'b11111
) (
  input  logic   clk,
  input  logic   rst_n,
  fetch_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [WORD_W-1:0] r_ir;
  logic              r_ir_valid;
  logic              r_mem_rd;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_busy;
  logic              r_halted;
  logic              r_jmp_pend;
  logic [ADDR_W-1:0] r_jmp_addr;

  // A jump arriving on the acknowledge cycle is the latest one and wins.
  logic              w_jmp_hit;
  logic [ADDR_W-1:0] w_jmp_tgt;
  logic [ADDR_W-1:0] w_pc_next;

  assign w_jmp_hit = bus.jump_en | r_jmp_pend;
  assign w_jmp_tgt = bus.jump_en ? bus.jump_addr : r_jmp_addr;
  // Sequential PC wraps naturally at 2^ADDR_W.
  assign w_pc_next = w_jmp_hit ? w_jmp_tgt : (r_mem_addr + ADDR_W'(1));

  // Fetch FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pc       <= '0;
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_mem_addr <= '0;
      r_busy     <= 1'b0;
      r_halted   <= 1'b0;
      r_jmp_pend <= 1'b0;
      r_jmp_addr <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.fetch_req) begin
            r_mem_addr <= bus.jump_en ? bus.jump_addr : r_pc;
            r_mem_rd   <= 1'b1;
            r_ir_valid <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_WAIT;
          end
          if (bus.jump_en) begin
            r_pc <= bus.jump_addr;
          end
        end

        ST_WAIT: begin
          if (bus.mem_ack) begin
            r_ir       <= bus.mem_rdata;
            r_ir_valid <= 1'b1;
            r_mem_rd   <= 1'b0;
            r_busy     <= 1'b0;
            r_pc       <= w_pc_next;
            r_jmp_pend <= 1'b0;
            if (bus.mem_rdata[WORD_W-1 -: 5] == HALT_OP) begin
              r_halted <= 1'b1;
              r_state  <= ST_HALT;
            end else begin
              r_state  <= ST_IDLE;
            end
          end else if (bus.jump_en) begin
            r_jmp_pend <= 1'b1;
            r_jmp_addr <= bus.jump_addr;
          end
        end

        ST_HALT: begin
          r_state <= ST_HALT;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.mem_rd   = r_mem_rd;
  assign bus.mem_addr = r_mem_addr;
  assign bus.ir       = r_ir;
  // Opcode decodes straight from IR so the control unit sees it with ir_valid.
  assign bus.opcode   = r_ir[WORD_W-1 -: 5];
  assign bus.ir_valid = r_ir_valid;
  assign bus.busy     = r_busy;
  assign bus.halted   = r_halted;
  assign bus.pc       = r_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a driver issues fetches, a memory
// responder answers with programmable latency, and a monitor pops expected
// results from a scoreboard queue whenever ir_valid rises.
module tb_fetch_unit;

  logic clk;
  logic rst_n;

  fetch_if #(.ADDR_W(8), .WORD_W(16)) bus ();

  fetch_unit #(.ADDR_W(8), .WORD_W(16), .HALT_OP(5'b11111)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] word;
    logic [7:0]  pc;
    logic        halt;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] mem [256];
  logic [7:0]  m_pc;
  int          n_checks = 0;
  int          n_fail   = 0;

  int          ack_lat  = 1;
  bit          chk_wait = 1'b1;
  logic [7:0]  last_addr;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endfunction

  // Memory responder: acknowledges each read ack_lat cycles after mem_rd rises.
  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.mem_rd) begin
        logic [7:0] a;
        int         lat;
        a         = bus.mem_addr;
        lat       = ack_lat;
        last_addr = a;
        for (int k = 1; k <= lat; k++) begin
          if (k > 1) @(negedge clk);
          if (chk_wait) begin
            chk("wait_mem_rd", 32'(bus.mem_rd), 32'd1);
            chk("wait_addr_stable", 32'(bus.mem_addr), 32'(a));
            chk("wait_busy", 32'(bus.busy), 32'd1);
          end
          if (k == lat) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = mem[a];
          end
        end
        @(negedge clk);
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 16'($urandom);
      end
    end
  end

  // Monitor: every rising ir_valid must match the oldest expectation.
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.ir_valid && !prev) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_ir_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("fetch_addr", 32'(last_addr), 32'(e.addr));
          chk("ir", 32'(bus.ir), 32'(e.word));
          chk("opcode", 32'(bus.opcode), 32'(e.word[15:11]));
          chk("pc", 32'(bus.pc), 32'(e.pc));
          chk("halted", 32'(bus.halted), 32'(e.halt));
          chk("done_mem_rd", 32'(bus.mem_rd), 32'd0);
          chk("done_busy", 32'(bus.busy), 32'd0);
        end
      end
      prev = bus.ir_valid;
    end
  end

  // Issue one fetch starting at a negedge; returns at the negedge after ack.
  task automatic do_fetch(input bit jnow, input logic [7:0] ja, input int lat,
                          input bit pulse, input bit rj, input bit fwj,
                          input logic [7:0] wja);
    bit         jf [8];
    logic [7:0] jd [8];
    exp_t       e;
    for (int k = 0; k < 8; k++) begin
      jf[k] = rj && (k >= 1) && (k < lat) && ($urandom_range(0, 2) == 0);
      jd[k] = 8'($urandom);
    end
    if (fwj) begin
      for (int k = 0; k < 8; k++) jf[k] = 1'b0;
      jf[1] = 1'b1;
      jd[1] = wja;
    end
    // Reference: fetch address, then the latest jump seen during the wait
    // overrides the sequential successor.
    e.addr = jnow ? ja : m_pc;
    e.word = mem[e.addr];
    e.pc   = e.addr + 8'd1;
    for (int k = 1; k < lat; k++) if (jf[k]) e.pc = jd[k];
    e.halt = (e.word[15:11] == 5'b11111);
    sb_q.push_back(e);
    m_pc = e.pc;

    ack_lat       = lat;
    bus.fetch_req = 1'b1;
    bus.jump_en   = jnow;
    bus.jump_addr = ja;
    @(negedge clk);
    for (int k = 1; k <= lat; k++) begin
      bus.fetch_req = pulse ? 1'($urandom) : 1'b0;
      bus.jump_en   = (k < lat) ? jf[k] : 1'b0;
      bus.jump_addr = jd[k];
      @(negedge clk);
    end
    bus.fetch_req = 1'b0;
    bus.jump_en   = 1'b0;
  endtask

  task automatic idle_jump(input logic [7:0] ja);
    bus.jump_en   = 1'b1;
    bus.jump_addr = ja;
    m_pc          = ja;
    @(negedge clk);
    bus.jump_en   = 1'b0;
    chk("idle_jump_pc", 32'(bus.pc), 32'(ja));
    chk("idle_jump_no_rd", 32'(bus.mem_rd), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_rd"}, 32'(bus.mem_rd), 32'd0);
    chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
    chk({tag, "_ir"}, 32'(bus.ir), 32'd0);
    chk({tag, "_ir_valid"}, 32'(bus.ir_valid), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_halted"}, 32'(bus.halted), 32'd0);
    chk({tag, "_pc"}, 32'(bus.pc), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [15:0] w;
    logic [7:0]  hpc;
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if (w[15:11] == 5'b11111) w[15] = 1'b0;
      mem[i] = w;
    end
    mem[0] = 16'h3A05;

    rst_n         = 1'b0;
    bus.fetch_req = 1'b0;
    bus.jump_en   = 1'b0;
    bus.jump_addr = '0;
    m_pc          = 8'd0;
    #1;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // First fetch from address 0, one-cycle acknowledge.
    do_fetch(1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'h00);
    // Long latency with stray fetch_req pulses during the wait.
    do_fetch(1'b0, 8'h00, 4, 1'b1, 1'b0, 1'b0, 8'h00);
    // Jump and fetch together in IDLE.
    do_fetch(1'b1, 8'h40, 2, 1'b0, 1'b0, 1'b0, 8'h00);
    // Jump recorded while the fetch is outstanding.
    do_fetch(1'b0, 8'h00, 3, 1'b0, 1'b0, 1'b1, 8'h10);
    // Wrap at the top of the address space.
    idle_jump(8'hFF);
    do_fetch(1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'h00);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 3) == 0) idle_jump(8'($urandom));
        else @(negedge clk);
      end
      do_fetch(1'($urandom), 8'($urandom), $urandom_range(1, 6),
               1'($urandom), 1'b1, 1'b0, 8'h00);
    end

    // Reset during an outstanding fetch; the late acknowledge is ignored.
    chk_wait      = 1'b0;
    ack_lat       = 5;
    bus.fetch_req = 1'b1;
    bus.jump_en   = 1'b1;
    bus.jump_addr = 8'h77;
    @(negedge clk);
    bus.fetch_req = 1'b0;
    bus.jump_en   = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_reset_mem_rd", 32'(bus.mem_rd), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_pc  = 8'd0;
    @(negedge clk);
    chk("late_ack_ir_valid", 32'(bus.ir_valid), 32'd0);
    chk("late_ack_mem_rd", 32'(bus.mem_rd), 32'd0);
    chk("late_ack_pc", 32'(bus.pc), 32'd0);
    chk_wait = 1'b1;
    do_fetch(1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b0, 8'h00);

    // Halt: fetch F800 and confirm the unit stays frozen.
    mem[8'h80] = 16'hF800;
    do_fetch(1'b1, 8'h80, 2, 1'b0, 1'b0, 1'b0, 8'h00);
    hpc = m_pc;
    for (int i = 0; i < 6; i++) begin
      bus.fetch_req = 1'b1;
      bus.jump_en   = 1'b1;
      bus.jump_addr = 8'($urandom);
      @(negedge clk);
      chk("halt_no_rd", 32'(bus.mem_rd), 32'd0);
      chk("halt_flag", 32'(bus.halted), 32'd1);
      chk("halt_ir", 32'(bus.ir), 32'hF800);
      chk("halt_pc", 32'(bus.pc), 32'(hpc));
    end
    bus.fetch_req = 1'b0;
    bus.jump_en   = 1'b0;
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
